// File: rtl/approx_err_pkg.sv
`default_nettype none
// ============================================================================
// Module   : approx_err_pkg
// Purpose  : Shared definitions for the approximate-arithmetic error monitors:
//            default widths, the run-control FSM state encoding and the
//            saturating-add helpers used by the on-chip accumulators.
// Macros   : none
// Revision : 1.0 - initial release
// ============================================================================
package approx_err_pkg;

  // Default widths for the 8-bit approximate-adder family.
  localparam int c_def_w     = 8;   // operand width
  localparam int c_def_cnt_w = 17;  // covers 2^16 exhaustive operand pairs
  localparam int c_def_sum_w = 26;  // c_def_w + 1 + c_def_cnt_w

  // Run-control FSM, explicitly 2-bit encoded.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Unsigned saturating add on a w-bit accumulator (w < 64). Operands are
  // carried in 64-bit containers so one helper serves any accumulator width;
  // both inputs must already fit in w bits.
  function automatic logic [63:0] sat_add_u(input logic [63:0] a,
                                            input logic [63:0] b,
                                            input int          w);
    logic [64:0] s;
    logic [64:0] mx;
    s  = {1'b0, a} + {1'b0, b};
    mx = (65'd1 << w) - 65'd1;
    return (s > mx) ? mx[63:0] : s[63:0];
  endfunction

  // Signed saturating add clamped to the w-bit two's-complement range
  // (w < 64). Inputs are sign-extended to 64 bits by the caller.
  function automatic logic signed [63:0] sat_add_s(input logic signed [63:0] a,
                                                   input logic signed [63:0] b,
                                                   input int                 w);
    logic signed [64:0] s;
    logic signed [64:0] mx;
    logic signed [64:0] mn;
    s  = {a[63], a} + {b[63], b};
    mx = (65'sd1 <<< (w - 1)) - 65'sd1;
    mn = -mx - 65'sd1;
    if (s > mx) begin
      return mx[63:0];
    end else if (s < mn) begin
      return mn[63:0];
    end else begin
      return s[63:0];
    end
  endfunction

endpackage
`default_nettype wire

// File: rtl/approx_err_dist.sv
`default_nettype none
// ============================================================================
// Module   : approx_err_dist
// Purpose  : Combinational error distance |exact - approx| between an exact
//            and an approximate (W+1)-bit result. Shared by the adder monitor
//            and future approximate-multiplier monitors.
// Ports    : exact  in  W+1  exact reference result
//            approx in  W+1  approximate result
//            ed     out W+1  absolute error distance
// Macros   : none
// Revision : 1.0 - initial release
// ============================================================================
module approx_err_dist
  import approx_err_pkg::*;
#(
  parameter int W = c_def_w
) (
  input  logic [W:0] exact,
  input  logic [W:0] approx,
  output logic [W:0] ed
);

  // One extra bit plus sign so the difference never wraps.
  logic signed [W+1:0] w_diff;

  assign w_diff = $signed({1'b0, exact}) - $signed({1'b0, approx});

  // |diff| always fits in W+1 bits; negating only the low bits gives the same
  // result as negating the full word and truncating.
  assign ed = w_diff[W+1] ? (~w_diff[W:0] + (W+1)'(1)) : w_diff[W:0];

endmodule
`default_nettype wire

// File: rtl/approx_adder_error_monitor.sv
`default_nettype none
// ============================================================================
// Module   : approx_adder_error_monitor
// Purpose  : On-chip error characterisation of an approximate adder. Accepts
//            {a, b, cin, approx} samples, recomputes the exact sum and
//            accumulates error count, sum / maximum of error distance and the
//            operands of the first worst-case sample.
// Ports    : clk, rst_n            clock, asynchronous active-low reset
//            start, n_samples      run start pulse and sample budget
//            in_valid/in_ready     sample handshake
//            in_a, in_b, in_cin    operands
//            in_approx             approximate result {Cout,S}
//            busy, done            run status
//            sample_cnt, err_cnt   accepted samples / samples with ED != 0
//            sum_ed, max_ed        saturating sum and maximum of ED
//            worst_a, worst_b      operands of first sample reaching max_ed
//            bias_sum              (SIGNED_BIAS_EN only) sat. sum(approx-exact)
// Macros   : SIGNED_BIAS_EN - adds the signed bias accumulator and port
// Revision : 1.0 - initial release
// ============================================================================
module approx_adder_error_monitor
  import approx_err_pkg::*;
#(
  parameter int W     = c_def_w,
  parameter int CNT_W = c_def_cnt_w,
  parameter int SUM_W = c_def_sum_w
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [CNT_W-1:0]        n_samples,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [W-1:0]            in_a,
  input  logic [W-1:0]            in_b,
  input  logic                    in_cin,
  input  logic [W:0]              in_approx,
  output logic                    busy,
  output logic                    done,
  output logic [CNT_W-1:0]        sample_cnt,
  output logic [CNT_W-1:0]        err_cnt,
  output logic [SUM_W-1:0]        sum_ed,
  output logic [W:0]              max_ed,
  output logic [W-1:0]            worst_a,
`ifdef SIGNED_BIAS_EN
  output logic signed [SUM_W-1:0] bias_sum,
`endif
  output logic [W-1:0]            worst_b
);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_e           r_state;
  logic [CNT_W-1:0] r_n_lat;
  logic [CNT_W-1:0] r_sample_cnt;

  // Stage 1: exact sum and captured sample
  logic             r_s1_valid;
  logic [W:0]       r_s1_exact;
  logic [W:0]       r_s1_approx;
  logic [W-1:0]     r_s1_a;
  logic [W-1:0]     r_s1_b;

  // Stage 2 occupancy: the accumulators below are the stage-2 registers
  logic             r_s2_valid;

  logic [CNT_W-1:0] r_err_cnt;
  logic [SUM_W-1:0] r_sum_ed;
  logic [W:0]       r_max_ed;
  logic [W-1:0]     r_worst_a;
  logic [W-1:0]     r_worst_b;

  logic             w_start_ok;
  logic             w_xfer;
  logic             w_last_xfer;
  logic [W:0]       w_exact;
  logic [W:0]       w_ed;

  // start only takes effect when no run is in flight.
  assign w_start_ok  = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign in_ready    = (r_state == ST_RUN) && (r_sample_cnt < r_n_lat);
  assign w_xfer      = in_valid && in_ready;
  assign w_last_xfer = w_xfer && ((r_sample_cnt + CNT_W'(1)) == r_n_lat);
  assign w_exact     = {1'b0, in_a} + {1'b0, in_b} + {{W{1'b0}}, in_cin};

  // --------------------------------------------------------------------------
  // Run-control FSM and sample counter
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_n_lat      <= '0;
      r_sample_cnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_n_lat      <= n_samples;
            r_sample_cnt <= '0;
            // An empty run still passes through DRAIN so done timing is uniform.
            r_state      <= (n_samples == '0) ? ST_DRAIN : ST_RUN;
          end
        end
        ST_RUN: begin
          if (w_xfer) begin
            r_sample_cnt <= r_sample_cnt + CNT_W'(1);
            if (w_last_xfer) begin
              r_state <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (!r_s1_valid && !r_s2_valid) begin
            r_state <= ST_DONE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Stage 1 capture
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid  <= 1'b0;
      r_s1_exact  <= '0;
      r_s1_approx <= '0;
      r_s1_a      <= '0;
      r_s1_b      <= '0;
      r_s2_valid  <= 1'b0;
    end else begin
      r_s1_valid <= w_xfer;
      r_s2_valid <= r_s1_valid;
      if (w_xfer) begin
        r_s1_exact  <= w_exact;
        r_s1_approx <= in_approx;
        r_s1_a      <= in_a;
        r_s1_b      <= in_b;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stage 2: error distance and accumulators
  // --------------------------------------------------------------------------
  approx_err_dist #(
    .W (W)
  ) u_err_dist (
    .exact  (r_s1_exact),
    .approx (r_s1_approx),
    .ed     (w_ed)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_cnt <= '0;
      r_sum_ed  <= '0;
      r_max_ed  <= '0;
      r_worst_a <= '0;
      r_worst_b <= '0;
    end else if (w_start_ok) begin
      r_err_cnt <= '0;
      r_sum_ed  <= '0;
      r_max_ed  <= '0;
      r_worst_a <= '0;
      r_worst_b <= '0;
    end else if (r_s1_valid) begin
      if (w_ed != '0) begin
        r_err_cnt <= r_err_cnt + CNT_W'(1);
      end
      r_sum_ed <= SUM_W'(sat_add_u(64'(r_sum_ed), 64'(w_ed), SUM_W));
      // Strictly greater: on a tie the earliest worst-case sample is kept.
      if (w_ed > r_max_ed) begin
        r_max_ed  <= w_ed;
        r_worst_a <= r_s1_a;
        r_worst_b <= r_s1_b;
      end
    end
  end

`ifdef SIGNED_BIAS_EN
  // Signed skew of the approximate adder: sum of (approx - exact).
  logic signed [W+1:0]    w_bias_diff;
  logic signed [SUM_W-1:0] r_bias_sum;

  assign w_bias_diff = $signed({1'b0, r_s1_approx}) - $signed({1'b0, r_s1_exact});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bias_sum <= '0;
    end else if (w_start_ok) begin
      r_bias_sum <= '0;
    end else if (r_s1_valid) begin
      r_bias_sum <= SUM_W'(sat_add_s(64'(r_bias_sum), 64'(w_bias_diff), SUM_W));
    end
  end

  assign bias_sum = r_bias_sum;
`endif

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign busy       = (r_state == ST_RUN) || (r_state == ST_DRAIN);
  assign done       = (r_state == ST_DONE);
  assign sample_cnt = r_sample_cnt;
  assign err_cnt    = r_err_cnt;
  assign sum_ed     = r_sum_ed;
  assign max_ed     = r_max_ed;
  assign worst_a    = r_worst_a;
  assign worst_b    = r_worst_b;

endmodule
`default_nettype wire

// File: tb/tb_approx_adder_error_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_approx_adder_error_monitor
// Purpose  : Directed self-checking bench for approx_adder_error_monitor with
//            hand-computed expected statistics.
// Macros   : SIGNED_BIAS_EN - also connects and checks bias_sum
// Revision : 1.0 - initial release
// ============================================================================
module tb_approx_adder_error_monitor;

  localparam int W     = 8;
  localparam int CNT_W = 17;
  localparam int SUM_W = 26;

  logic                    clk;
  logic                    rst_n;
  logic                    start;
  logic [CNT_W-1:0]        n_samples;
  logic                    in_valid;
  logic                    in_ready;
  logic [W-1:0]            in_a;
  logic [W-1:0]            in_b;
  logic                    in_cin;
  logic [W:0]              in_approx;
  logic                    busy;
  logic                    done;
  logic [CNT_W-1:0]        sample_cnt;
  logic [CNT_W-1:0]        err_cnt;
  logic [SUM_W-1:0]        sum_ed;
  logic [W:0]              max_ed;
  logic [W-1:0]            worst_a;
  logic [W-1:0]            worst_b;
`ifdef SIGNED_BIAS_EN
  logic signed [SUM_W-1:0] bias_sum;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  approx_adder_error_monitor #(
    .W     (W),
    .CNT_W (CNT_W),
    .SUM_W (SUM_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .n_samples  (n_samples),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_cin     (in_cin),
    .in_approx  (in_approx),
    .busy       (busy),
    .done       (done),
    .sample_cnt (sample_cnt),
    .err_cnt    (err_cnt),
    .sum_ed     (sum_ed),
    .max_ed     (max_ed),
    .worst_a    (worst_a),
`ifdef SIGNED_BIAS_EN
    .bias_sum   (bias_sum),
`endif
    .worst_b    (worst_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 ns after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [CNT_W-1:0] n);
    start     = 1'b1;
    n_samples = n;
    step();
    start     = 1'b0;
  endtask

  // Present one sample and hold it until it transfers.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic cin, input logic [W:0] ap);
    int t;
    in_a      = a;
    in_b      = b;
    in_cin    = cin;
    in_approx = ap;
    in_valid  = 1'b1;
    t = 0;
    while (!in_ready && t < 20) begin
      step();
      t++;
    end
    if (t >= 20) begin
      n_tests++;
      n_fail++;
      $error("FAIL send_timeout: observed in_ready=0 for %0d cycles expected 1", t);
    end
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_done(output int cycles);
    cycles = 0;
    while (!done && cycles < 30) begin
      step();
      cycles++;
    end
    if (!done) begin
      n_tests++;
      n_fail++;
      $error("FAIL done_timeout: observed done=0 after %0d cycles expected 1", cycles);
    end
  endtask

  initial begin
    int            cyc;
    int            xfers;
    logic          saw_ready;
    logic [W-1:0]  va;
    logic [W-1:0]  vb;
    logic [W:0]    vx;

    rst_n     = 1'b0;
    start     = 1'b0;
    n_samples = '0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_cin    = 1'b0;
    in_approx = '0;

    // ---------------- reset state ----------------
    #3;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_sample_cnt", 64'(sample_cnt), 64'd0);
    check("rst_sum_ed", 64'(sum_ed), 64'd0);
    check("rst_max_ed", 64'(max_ed), 64'd0);
    step();
    step();
    rst_n = 1'b1;
    step();

    // ---------------- exhaustive exact adder ----------------
    pulse_start(17'd65536);
    check("exh_busy", 64'(busy), 64'd1);
    for (int i = 0; i < 65536; i++) begin
      va = i[15:8];
      vb = i[7:0];
      vx = {1'b0, va} + {1'b0, vb};
      send(va, vb, 1'b0, vx);
    end
    wait_done(cyc);
    check("exh_done_latency_ge3", 64'(cyc >= 3), 64'd1);
    check("exh_sample_cnt", 64'(sample_cnt), 64'd65536);
    check("exh_err_cnt", 64'(err_cnt), 64'd0);
    check("exh_sum_ed", 64'(sum_ed), 64'd0);
    check("exh_max_ed", 64'(max_ed), 64'd0);

    // ---------------- two-sample run, restarted from DONE ----------------
    pulse_start(17'd2);
    check("two_done_drops", 64'(done), 64'd0);
    check("two_cnt_cleared", 64'(sample_cnt), 64'd0);
    send(8'h0F, 8'h01, 1'b0, 9'h00F);
    check("two_latency_not_yet", 64'(err_cnt), 64'd0);
    step();
    check("two_s1_err_cnt", 64'(err_cnt), 64'd1);
    check("two_s1_max_ed", 64'(max_ed), 64'd1);
    check("two_s1_worst_b", 64'(worst_b), 64'h01);
    send(8'h0F, 8'h0F, 1'b0, 9'h00F);
    wait_done(cyc);
    check("two_sample_cnt", 64'(sample_cnt), 64'd2);
    check("two_err_cnt", 64'(err_cnt), 64'd2);
    check("two_sum_ed", 64'(sum_ed), 64'd16);
    check("two_max_ed", 64'(max_ed), 64'd15);
    check("two_worst_a", 64'(worst_a), 64'h0F);
    check("two_worst_b", 64'(worst_b), 64'h0F);

    // ---------------- tie on max keeps earliest ----------------
    pulse_start(17'd2);
    send(8'h03, 8'h04, 1'b0, 9'h000);  // exact 7, ED 7
    send(8'h05, 8'h02, 1'b0, 9'h00E);  // exact 7, ED 7
    wait_done(cyc);
    check("tie_max_ed", 64'(max_ed), 64'd7);
    check("tie_worst_a", 64'(worst_a), 64'h03);
    check("tie_worst_b", 64'(worst_b), 64'h04);
    check("tie_sum_ed", 64'(sum_ed), 64'd14);

    // ---------------- empty run ----------------
    pulse_start(17'd0);
    check("empty_busy", 64'(busy), 64'd1);
    saw_ready = in_ready;
    cyc = 0;
    while (!done && cyc < 3) begin
      step();
      cyc++;
      saw_ready = saw_ready | in_ready;
    end
    check("empty_done_within3", 64'(done), 64'd1);
    check("empty_never_ready", 64'(saw_ready), 64'd0);
    check("empty_sample_cnt", 64'(sample_cnt), 64'd0);
    check("empty_err_cnt", 64'(err_cnt), 64'd0);
    check("empty_sum_ed", 64'(sum_ed), 64'd0);
    check("empty_max_ed", 64'(max_ed), 64'd0);
    check("empty_worst_a", 64'(worst_a), 64'd0);

    // ---------------- back-pressure and ignored start ----------------
    pulse_start(17'd3);
    in_a      = 8'h01;
    in_b      = 8'h01;
    in_cin    = 1'b0;
    in_approx = 9'h000;               // exact 2, ED 2
    in_valid  = 1'b1;
    xfers     = 0;
    for (int k = 0; k < 6; k++) begin
      if (in_ready) xfers++;
      if (k == 1) begin
        start     = 1'b1;
        n_samples = 17'd7;
      end
      step();
      start = 1'b0;
    end
    in_valid = 1'b0;
    wait_done(cyc);
    check("bp_transfers", 64'(xfers), 64'd3);
    check("bp_sample_cnt", 64'(sample_cnt), 64'd3);
    check("bp_err_cnt", 64'(err_cnt), 64'd3);
    check("bp_sum_ed", 64'(sum_ed), 64'd6);
    check("bp_max_ed", 64'(max_ed), 64'd2);

    // ---------------- reset mid-run ----------------
    pulse_start(17'd200);
    for (int i = 0; i < 100; i++) begin
      va = 8'(i + 1);
      vb = 8'(i);
      vx = {1'b0, va} + {1'b0, vb} + 9'd1;   // ED 1
      send(va, vb, 1'b0, vx);
    end
    check("mid_sample_cnt", 64'(sample_cnt), 64'd100);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_in_ready", 64'(in_ready), 64'd0);
    check("mid_rst_sample_cnt", 64'(sample_cnt), 64'd0);
    check("mid_rst_err_cnt", 64'(err_cnt), 64'd0);
    check("mid_rst_sum_ed", 64'(sum_ed), 64'd0);
    check("mid_rst_max_ed", 64'(max_ed), 64'd0);
    check("mid_rst_worst_a", 64'(worst_a), 64'd0);
`ifdef SIGNED_BIAS_EN
    check("mid_rst_bias", 64'(bias_sum), 64'd0);
`endif
    #3;
    rst_n = 1'b1;
    step();
    check("post_rst_idle_busy", 64'(busy), 64'd0);
    pulse_start(17'd2);
    send(8'h10, 8'h20, 1'b0, 9'h02F);  // exact 0x30, approx-exact = -1
    send(8'h01, 8'h01, 1'b1, 9'h006);  // exact 0x03, approx-exact = +3
    wait_done(cyc);
    check("post_sample_cnt", 64'(sample_cnt), 64'd2);
    check("post_err_cnt", 64'(err_cnt), 64'd2);
    check("post_sum_ed", 64'(sum_ed), 64'd4);
    check("post_max_ed", 64'(max_ed), 64'd3);
    check("post_worst_a", 64'(worst_a), 64'h01);
    check("post_worst_b", 64'(worst_b), 64'h01);
`ifdef SIGNED_BIAS_EN
    check("post_bias_sum", 64'(bias_sum), 64'd2);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
